// File: rtl/audio_interp_feeder_pkg.sv
// audio_interp_feeder_pkg: shared audio widths, volume unity, midscale and ramp state encoding
package audio_interp_feeder_pkg;
  localparam int AUDIO_W = 16;
  localparam int VOL_W = 7;
  localparam int VOL_UNITY = 64;
  localparam logic [AUDIO_W-1:0] MIDSCALE = 16'h8000;
  typedef enum logic {IDLE, RAMP} state_t;
endpackage

// File: rtl/audio_vol_scale.sv
// audio_vol_scale: clamped volume multiply, then offset-binary conversion with a one-clock strobe
module audio_vol_scale
  import audio_interp_feeder_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic signed [AUDIO_W-1:0] in_sample,
  input  logic [VOL_W-1:0]          volume,
  output logic [AUDIO_W-1:0]        out_sample,
  output logic                      out_strobe
);
  localparam int PW = AUDIO_W + VOL_W;
  localparam int SH = $clog2(VOL_UNITY);
  logic [VOL_W-1:0] vol;
  logic signed [PW-1:0] product;
  logic [AUDIO_W-1:0] scaled;
  logic scaled_valid;
  assign vol = volume > VOL_W'(VOL_UNITY) ? VOL_W'(VOL_UNITY) : volume;
  assign product = PW'(in_sample) * PW'($signed({1'b0, vol}));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scaled <= '0;
      scaled_valid <= 1'b0;
      out_sample <= MIDSCALE;
      out_strobe <= 1'b0;
    end else begin
      scaled_valid <= in_valid;
      out_strobe <= scaled_valid;
      if (in_valid) scaled <= AUDIO_W'(product >>> SH);
      if (scaled_valid) out_sample <= scaled ^ MIDSCALE;
    end
  end
endmodule

// File: rtl/audio_interp_feeder.sv
// audio_interp_feeder: linear interpolation between mixer samples, one volume-scaled DAC value per PWM frame
module audio_interp_feeder
  import audio_interp_feeder_pkg::*;
#(
  parameter int LOG2_STEPS = 5,
  parameter int TICK_DIV   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AUDIO_W-1:0] in_sample,
  input  logic [VOL_W-1:0]   volume,
  output logic [AUDIO_W-1:0] out_sample,
  output logic               out_strobe,
  output logic               underrun
);
  localparam int AW = AUDIO_W + 1 + LOG2_STEPS;
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [LOG2_STEPS-1:0] step;
  logic pending, tick, last, advance, load, interp_valid;
  logic signed [AUDIO_W-1:0] hold, start, target, interp, interp_r;
  logic signed [AUDIO_W:0] delta;
  logic signed [AW-1:0] acc, acc_nx;
  assign in_ready = !pending;
  assign tick = cnt == CW'(TICK_DIV - 1);
  assign last = &step;
  assign advance = tick && state == RAMP;
  assign load = tick && pending && (state == IDLE || last);
  assign acc_nx = acc + {{LOG2_STEPS{delta[AUDIO_W]}}, delta};
  // the final step lands on target exactly so no truncation residue carries into the next ramp
  assign interp = last ? target : start + AUDIO_W'(acc_nx >>> LOG2_STEPS);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      step <= '0;
      pending <= 1'b0;
      hold <= '0;
      start <= '0;
      target <= '0;
      delta <= '0;
      acc <= '0;
      interp_r <= '0;
      interp_valid <= 1'b0;
      underrun <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      interp_valid <= advance;
      pending <= !load && (pending || in_valid);
      if (in_valid && !pending) hold <= in_sample;
      if (advance) begin
        interp_r <= interp;
        acc <= acc_nx;
        step <= step + 1'b1;
        if (last && !pending) begin
          underrun <= 1'b1;
          state <= IDLE;
        end
      end
      if (load) begin
        start <= target;
        delta <= {hold[AUDIO_W-1], hold} - {target[AUDIO_W-1], target};
        target <= hold;
        acc <= '0;
        step <= '0;
        state <= RAMP;
      end
    end
  end
  audio_vol_scale u_vol (
    .clk(clk),
    .reset(reset),
    .in_valid(interp_valid),
    .in_sample(interp_r),
    .volume(volume),
    .out_sample(out_sample),
    .out_strobe(out_strobe)
  );
endmodule
